signed_divider_8bit: RTL and testbench



---
 rtl/signed_divider_8bit.sv | 146 ++++++++++++++
 tb/tb_signed_divider_8bit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_8bit.sv
// signed_divider_8bit
//
// Sequential 8-bit two's-complement divider. It captures a signed dividend
// and divisor, then runs one restoring-division step per clock on the
// unsigned magnitudes (MSB first). After the last step it applies the signs
// and presents a truncated-toward-zero quotient and a remainder that takes
// the sign of the dividend.
//
// Handshake: pause=0 while IDLE or DONE captures A/B on that edge and starts
// a division. pause=1 holds the block, so DONE keeps Q/R/flag indefinitely.
// pause is ignored while a division is running. flag is a registered
// "result valid" level. It rises on the edge that writes Q/R and falls on the
// edge that captures the next operands.
//
// Timing: capture on edge 0, division steps on edges 1..8, and Q/R/flag
// written on edge 9.
//
// Special results:
//   B == 0            -> Q = 8'hFF, R = A
//   A == -128, B == -1 -> Q = 8'h80, R = 8'h00
// Both take the normal latency.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (highest priority)
//   pause     operand hold / start control
//   A, B      signed dividend / divisor
//   Q, R      signed quotient / remainder (registered)
//   flag      result valid (registered)
//   dbg_state current FSM state (0 IDLE, 1 CALC, 2 DONE)

module signed_divider_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       flag,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] a_raw;      // original dividend, needed for the B == 0 result
    logic       a_neg;
    logic       b_neg;
    logic [7:0] b_mag;
    logic [7:0] dvd;        // dividend magnitude, shifted out MSB first
    logic [7:0] quo;        // quotient magnitude, shifted in LSB first
    logic [8:0] prem;       // partial remainder
    logic [3:0] cnt;

    // One restoring step. The shifted remainder is at most 2*127+1, so it
    // fits in 9 bits. The trial difference is widened to 10 bits so that
    // its MSB is a clean "negative" indicator.
    logic [8:0] rem_sh;
    logic [9:0] diff;
    logic       q_bit;

    // Sign fix-up of the finished magnitudes
    logic [7:0] q_fin;
    logic [7:0] r_fin;
    logic       div_zero;
    logic       ovf;

    always_comb begin
        rem_sh   = {prem[7:0], dvd[7]};
        diff     = {1'b0, rem_sh} - {2'b00, b_mag};
        q_bit    = ~diff[9];

        div_zero = (b_mag == 8'd0);
        ovf      = (a_raw == 8'h80) && b_neg && (b_mag == 8'd1);

        q_fin    = (a_neg ^ b_neg) ? (~quo + 8'd1) : quo;
        r_fin    = a_neg ? (~prem[7:0] + 8'd1) : prem[7:0];
        if (div_zero) begin
            q_fin = 8'hFF;
            r_fin = a_raw;
        end else if (ovf) begin
            q_fin = 8'h80;
            r_fin = 8'h00;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            Q     <= 8'h00;
            R     <= 8'h00;
            flag  <= 1'b0;
            cnt   <= 4'd0;
            a_raw <= 8'h00;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            b_mag <= 8'h00;
            dvd   <= 8'h00;
            quo   <= 8'h00;
            prem  <= 9'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (!pause) begin
                        // Magnitude of -128 is 128, which is still
                        // representable as an 8-bit unsigned value.
                        a_raw <= A;
                        a_neg <= A[7];
                        b_neg <= B[7];
                        dvd   <= A[7] ? (~A + 8'd1) : A;
                        b_mag <= B[7] ? (~B + 8'd1) : B;
                        quo   <= 8'h00;
                        prem  <= 9'd0;
                        cnt   <= 4'd0;
                        flag  <= 1'b0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt == 4'd8) begin
                        Q     <= q_fin;
                        R     <= r_fin;
                        flag  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        prem <= q_bit ? diff[8:0] : rem_sh;
                        quo  <= {quo[6:0], q_bit};
                        dvd  <= {dvd[6:0], 1'b0};
                        cnt  <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_8bit.sv
// Testbench for signed_divider_8bit: directed table of signed divisions plus
// hand-written sequences for hold, mid-operation reset and back-to-back runs.

module tb_signed_divider_8bit;

    logic       clk;
    logic       rst;
    logic       pause;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       flag;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[12];

    signed_divider_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .A         (A),
        .B         (B),
        .Q         (Q),
        .R         (R),
        .flag      (flag),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Present operands with pause=0 for one edge (the capture edge), then
    // hold pause=1 and scramble A/B. Returns the number of edges from
    // capture until flag is seen high, or -1 if it never rises within 20.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat);
        A     = a;
        B     = b;
        pause = 1'b0;
        @(posedge clk);
        #1;
        pause = 1'b1;
        A     = 8'($urandom_range(0, 255));
        B     = 8'($urandom_range(0, 255));
        chk("flag_low_after_capture", {31'd0, flag}, 32'd0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (flag) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_bad = 0;

        // {A, B, expected Q, expected R}
        vecs[0]  = '{8'hF9, 8'hF9, 8'h01, 8'h00};  // -7 / -7
        vecs[1]  = '{8'h0A, 8'hF9, 8'hFF, 8'h03};  // 10 / -7
        vecs[2]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE};  // -100 / 7
        vecs[3]  = '{8'h7F, 8'h02, 8'h3F, 8'h01};  // 127 / 2
        vecs[4]  = '{8'h2A, 8'h00, 8'hFF, 8'h2A};  // divide by zero
        vecs[5]  = '{8'h80, 8'hFF, 8'h80, 8'h00};  // -128 / -1 overflow
        vecs[6]  = '{8'h80, 8'h01, 8'h80, 8'h00};  // -128 / 1
        vecs[7]  = '{8'h05, 8'h0A, 8'h00, 8'h05};  // 5 / 10
        vecs[8]  = '{8'hF6, 8'h00, 8'hFF, 8'hF6};  // -10 / 0
        vecs[9]  = '{8'h80, 8'h07, 8'hEE, 8'hFE};  // -128 / 7 = -18 r -2
        vecs[10] = '{8'h7F, 8'h80, 8'h00, 8'h7F};  // 127 / -128
        vecs[11] = '{8'h81, 8'h7F, 8'hFF, 8'h00};  // -127 / 127

        // ---------------- reset ----------------
        rst   = 1'b1;
        pause = 1'b1;
        A     = 8'h00;
        B     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_Q", {24'd0, Q}, 32'h00);
        chk("reset_R", {24'd0, R}, 32'h00);
        chk("reset_flag", {31'd0, flag}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);

        // ---------------- first division with long hold ----------------
        do_div(8'hF9, 8'hF9, lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_Q", {24'd0, Q}, 32'h01);
        chk("t1_R", {24'd0, R}, 32'h00);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk("hold_flag", {31'd0, flag}, 32'd1);
            chk("hold_Q", {24'd0, Q}, 32'h01);
            chk("hold_R", {24'd0, R}, 32'h00);
        end
        chk("hold_state", {30'd0, dbg_state}, 32'd2);

        // ---------------- table ----------------
        for (int v = 0; v < 12; v++) begin
            do_div(vecs[v].a, vecs[v].b, lat);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd9);
            chk($sformatf("vec%0d_Q", v), {24'd0, Q}, {24'd0, vecs[v].q});
            chk($sformatf("vec%0d_R", v), {24'd0, R}, {24'd0, vecs[v].r});
        end

        // ---------------- reset in the middle of a division ----------------
        A     = 8'h80;
        B     = 8'h07;
        pause = 1'b0;
        @(posedge clk);            // edge 0: capture
        #1;
        pause = 1'b1;
        repeat (3) @(posedge clk); // edges 1..3
        #1;
        chk("midrst_Q_held", {24'd0, Q}, {24'd0, vecs[11].q});
        rst = 1'b1;
        @(posedge clk);            // edge 4: reset
        #1;
        rst = 1'b0;
        chk("midrst_Q", {24'd0, Q}, 32'h00);
        chk("midrst_R", {24'd0, R}, 32'h00);
        chk("midrst_flag", {31'd0, flag}, 32'd0);
        chk("midrst_state", {30'd0, dbg_state}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_flag_stays_low", {31'd0, flag}, 32'd0);
        end
        chk("midrst_state_idle", {30'd0, dbg_state}, 32'd0);

        // ---------------- back-to-back with pause held low ----------------
        A     = 8'h64;
        B     = 8'h0A;
        pause = 1'b0;
        @(posedge clk);            // edge 0: first capture
        #1;
        A = 8'hEC;
        B = 8'h03;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i < 9) chk("b2b_first_busy_flag", {31'd0, flag}, 32'd0);
        end
        chk("b2b_first_flag", {31'd0, flag}, 32'd1);
        chk("b2b_first_Q", {24'd0, Q}, 32'h0A);
        chk("b2b_first_R", {24'd0, R}, 32'h00);
        @(posedge clk);            // edge 10: second capture
        #1;
        chk("b2b_flag_drop", {31'd0, flag}, 32'd0);
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
        for (int i = 11; i <= 19; i++) begin
            @(posedge clk);
            #1;
            if (i < 19) begin
                chk("b2b_second_busy_flag", {31'd0, flag}, 32'd0);
                chk("b2b_Q_held_in_calc", {24'd0, Q}, 32'h0A);
            end
        end
        pause = 1'b1;
        chk("b2b_second_flag", {31'd0, flag}, 32'd1);
        chk("b2b_second_Q", {24'd0, Q}, 32'hFA);
        chk("b2b_second_R", {24'd0, R}, 32'hFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
